// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin memory port arbiter; optional watchdog via ARB_TIMEOUT_EN
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mem_arbiter #(
  parameter int DATA_WIDTH     = `DATA_WIDTH,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [31:0]           i_m0_addr,
  input  logic [DATA_WIDTH-1:0] i_m0_data,
  input  logic                  i_m0_wr_valid,
  output logic                  o_m0_wr_ready,
  output logic [DATA_WIDTH-1:0] o_m0_data,
  output logic                  o_m0_rd_valid,
  input  logic                  i_m0_rd_ready,
  input  logic                  i_m0_lock,
  input  logic [31:0]           i_m1_addr,
  input  logic [DATA_WIDTH-1:0] i_m1_data,
  input  logic                  i_m1_wr_valid,
  output logic                  o_m1_wr_ready,
  output logic [DATA_WIDTH-1:0] o_m1_data,
  output logic                  o_m1_rd_valid,
  input  logic                  i_m1_rd_ready,
  input  logic                  i_m1_lock,
  output logic [31:0]           o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_wr_valid,
  input  logic                  i_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd_valid,
  output logic                  o_rd_ready,
  output logic [1:0]            o_grant,
  output logic                  o_busy,
  output logic                  o_timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;     // index of the requester served most recently
  logic [BW-1:0] burst_q, burst_d;

  logic req0, req1, sel1, other_req, lock_sel, complete, timeout, win1;

  assign req0      = i_m0_wr_valid | i_m0_rd_ready;
  assign req1      = i_m1_wr_valid | i_m1_rd_ready;
  assign sel1      = grant_q[1];
  assign other_req = sel1 ? req0 : req1;
  assign lock_sel  = sel1 ? i_m1_lock : i_m0_lock;
  assign complete  = (state_q == BUSY) & ((o_wr_valid & i_wr_ready) | (i_rd_valid & o_rd_ready));
  // On a tie the requester not served last wins
  assign win1      = req1 & (~req0 | ~last_q);

  assign o_grant   = grant_q;
  assign o_busy    = (state_q == BUSY);
  assign o_timeout = timeout;

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;

  // Completion in the limit cycle takes priority over the abort
  assign timeout = (state_q == BUSY) & ~complete & (32'(wdog_q) == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog counts stalled BUSY cycles, clears on completion, abort or IDLE
  always_comb begin
    wdog_d = '0;
    if ((state_q == BUSY) && !complete && !timeout) wdog_d = wdog_q + WW'(1);
  end

  // Watchdog register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign timeout = 1'b0;
  wire unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  // Route the granted requester to memory and memory responses back to it only
  always_comb begin
    o_addr        = '0;
    o_data        = '0;
    o_wr_valid    = 1'b0;
    o_rd_ready    = 1'b0;
    o_m0_wr_ready = 1'b0;
    o_m0_rd_valid = 1'b0;
    o_m0_data     = '0;
    o_m1_wr_ready = 1'b0;
    o_m1_rd_valid = 1'b0;
    o_m1_data     = '0;
    if (state_q == BUSY) begin
      if (sel1) begin
        o_addr        = i_m1_addr;
        o_data        = i_m1_data;
        o_wr_valid    = i_m1_wr_valid;
        o_rd_ready    = i_m1_rd_ready & ~i_m1_wr_valid;
        o_m1_wr_ready = i_wr_ready;
        o_m1_rd_valid = i_rd_valid;
        o_m1_data     = i_data;
      end else begin
        o_addr        = i_m0_addr;
        o_data        = i_m0_data;
        o_wr_valid    = i_m0_wr_valid;
        o_rd_ready    = i_m0_rd_ready & ~i_m0_wr_valid;
        o_m0_wr_ready = i_wr_ready;
        o_m0_rd_valid = i_rd_valid;
        o_m0_data     = i_data;
      end
    end
  end

  // Arbitration, lock/burst handling and release
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        if (req0 | req1) begin
          grant_d = win1 ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          last_d = sel1;
          if (lock_sel && (!other_req || (32'(burst_q) + 32'd1 < 32'(MAX_BURST)))) begin
            if (32'(burst_q) < 32'(MAX_BURST - 1)) burst_d = burst_q + BW'(1);
          end else begin
            state_d = IDLE;
            grant_d = 2'b00;
            burst_d = '0;
          end
        end else if (timeout) begin
          last_d  = sel1;
          state_d = IDLE;
          grant_d = 2'b00;
          burst_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
        burst_d = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_wr_valid, m1_wr_valid, m0_rd_ready, m1_rd_ready, m0_lock, m1_lock;
  logic          m0_wr_ready, m1_wr_ready, m0_rd_valid, m1_rd_valid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_wr_valid, mem_wr_ready, mem_rd_valid, mem_rd_ready;
  logic [1:0]    grant;
  logic          busy, tmo;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(4), .TIMEOUT_CYCLES(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m0_addr(m0_addr), .i_m0_data(m0_wdata), .i_m0_wr_valid(m0_wr_valid),
    .o_m0_wr_ready(m0_wr_ready), .o_m0_data(m0_rdata), .o_m0_rd_valid(m0_rd_valid),
    .i_m0_rd_ready(m0_rd_ready), .i_m0_lock(m0_lock),
    .i_m1_addr(m1_addr), .i_m1_data(m1_wdata), .i_m1_wr_valid(m1_wr_valid),
    .o_m1_wr_ready(m1_wr_ready), .o_m1_data(m1_rdata), .o_m1_rd_valid(m1_rd_valid),
    .i_m1_rd_ready(m1_rd_ready), .i_m1_lock(m1_lock),
    .o_addr(mem_addr), .o_data(mem_wdata), .o_wr_valid(mem_wr_valid),
    .i_wr_ready(mem_wr_ready), .i_data(mem_rdata), .i_rd_valid(mem_rd_valid),
    .o_rd_ready(mem_rd_ready), .o_grant(grant), .o_busy(busy), .o_timeout(tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    m0_wr_valid = 0; m1_wr_valid = 0; m0_rd_ready = 0; m1_rd_ready = 0;
    m0_lock = 0; m1_lock = 0; mem_wr_ready = 0; mem_rd_valid = 0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    do_reset();
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", tmo, 1'b0);
    chk("rst_mem_wr_valid", mem_wr_valid, 1'b0);

    // 1: single read from m0
    m0_addr = 32'h10; m0_rd_ready = 1;
    #1;
    chk("t1_idle_rd_ready", mem_rd_ready, 1'b0);
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_rd_ready", mem_rd_ready, 1'b1);
    mem_rdata = 32'hAB; mem_rd_valid = 1;
    #1;
    chk("t1_m0_data", m0_rdata, 32'hAB);
    chk("t1_m0_rd_valid", m0_rd_valid, 1'b1);
    chk("t1_m1_rd_valid", m1_rd_valid, 1'b0);
    chk("t1_m1_data", m1_rdata, 32'h0);
    tick();
    clear_inputs();
    #1;
    chk("t1_release", grant, 2'b00);

    // 2: simultaneous writes after reset
    do_reset();
    m0_addr = 32'h20; m0_wdata = 32'h11; m0_wr_valid = 1;
    m1_addr = 32'h30; m1_wdata = 32'h22; m1_wr_valid = 1;
    tick();
    chk("t2_grant_m0", grant, 2'b01);
    chk("t2_addr_m0", mem_addr, 32'h20);
    chk("t2_data_m0", mem_wdata, 32'h11);
    mem_wr_ready = 1;
    #1;
    chk("t2_m0_wr_ready", m0_wr_ready, 1'b1);
    chk("t2_m1_wr_ready", m1_wr_ready, 1'b0);
    tick();
    m0_wr_valid = 0; mem_wr_ready = 0;
    #1;
    chk("t2_idle", grant, 2'b00);
    tick();
    chk("t2_grant_m1", grant, 2'b10);
    chk("t2_addr_m1", mem_addr, 32'h30);
    mem_wr_ready = 1;
    tick();
    mem_wr_ready = 0; m0_wr_valid = 1;
    tick();
    chk("t2_grant_m0_again", grant, 2'b01);
    mem_wr_ready = 1;
    tick();
    clear_inputs();
    tick();

    // 3: m1 locked burst capped at MAX_BURST while m0 waits
    m1_lock = 1; m1_wr_valid = 1; m1_addr = 32'h100; m0_wr_valid = 1; m0_addr = 32'h200;
    mem_wr_ready = 1;
    tick();
    cnt = 0;
    for (int i = 0; i < 10 && grant == 2'b10; i++) begin
      if (m1_wr_ready) cnt++;
      tick();
    end
    chk("t3_m1_writes", cnt, 4);
    chk("t3_idle_gap", grant, 2'b00);
    tick();
    chk("t3_grant_m0", grant, 2'b01);
    chk("t3_addr_m0", mem_addr, 32'h200);
    tick();
    clear_inputs();
    tick();

    // 4: write takes precedence over read for the same requester
    m0_addr = 32'h40; m0_wr_valid = 1; m0_rd_ready = 1; mem_rd_valid = 1; mem_rdata = 32'h55;
    tick();
    chk("t4_grant", grant, 2'b01);
    chk("t4_wr_valid", mem_wr_valid, 1'b1);
    chk("t4_rd_ready_masked", mem_rd_ready, 1'b0);
    chk("t4_m1_data", m1_rdata, 32'h0);
    tick();
    chk("t4_still_busy", grant, 2'b01);
    chk("t4_rd_ready_still_masked", mem_rd_ready, 1'b0);
    chk("t4_m1_rd_valid", m1_rd_valid, 1'b0);
    mem_wr_ready = 1;
    #1;
    chk("t4_wr_done", m0_wr_ready, 1'b1);
    chk("t4_m1_wr_ready", m1_wr_ready, 1'b0);
    tick();
    m0_wr_valid = 0; mem_wr_ready = 0;
    #1;
    chk("t4_idle", grant, 2'b00);
    tick();
    chk("t4_rd_ready", mem_rd_ready, 1'b1);
    chk("t4_rd_data", m0_rdata, 32'h55);
    chk("t4_m1_data_rd", m1_rdata, 32'h0);
    tick();
    clear_inputs();
    tick();

    // 5: asynchronous reset in BUSY
    m1_addr = 32'h50; m1_wr_valid = 1;
    tick();
    chk("t5_busy", busy, 1'b1);
    mem_wr_ready = 0;
    #1;
    rst = 1;
    #1;
    chk("t5_async_grant", grant, 2'b00);
    chk("t5_async_busy", busy, 1'b0);
    chk("t5_async_wr_valid", mem_wr_valid, 1'b0);
    chk("t5_async_addr", mem_addr, 32'h0);
    m0_wr_valid = 1; m0_addr = 32'h60;
    tick();
    rst = 0;
    tick();
    chk("t5_tie_m0", grant, 2'b01);
    clear_inputs();
    mem_wr_ready = 1; m0_wr_valid = 1;
    tick();
    clear_inputs();
    tick();

`ifdef ARB_TIMEOUT_EN
    // 6: watchdog abort hands the grant to the waiting requester
    do_reset();
    m0_rd_ready = 1; m0_addr = 32'h70; m1_wr_valid = 1; m1_addr = 32'h80;
    tick();
    chk("t6_grant_m0", grant, 2'b01);
    for (int c = 1; c < 8; c++) begin
      chk("t6_no_timeout", tmo, 1'b0);
      tick();
    end
    chk("t6_timeout", tmo, 1'b1);
    tick();
    chk("t6_idle", grant, 2'b00);
    chk("t6_pulse_end", tmo, 1'b0);
    tick();
    chk("t6_grant_m1", grant, 2'b10);
    clear_inputs();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter that shares the single external memory port between requester 0 (core fetch/execute bus) and requester 1 (debug/DMA loader). Uses the same valid/ready read and write handshakes as the core memory interface on every side. Round-robin grant, locked until the granted transaction handshakes. Optional burst lock is capped by a counter.

Parameters:
DATA_WIDTH, `DATA_WIDTH, width of read/write data on all ports
MAX_BURST, 4, max consecutive locked transactions for one requester while the other is requesting (>=1)
TIMEOUT_CYCLES, 255, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
i_clk  in  1  clock; all state updates on posedge
i_rst  in  1  reset, asynchronous, active-high
i_mN_addr  in  32  requester N address (N = 0, 1; the same set of ports exists per requester)
i_mN_data  in  DATA_WIDTH  requester N write data
i_mN_wr_valid  in  1  requester N write request
o_mN_wr_ready  out  1  write accepted by memory, routed only to the granted requester
o_mN_data  out  DATA_WIDTH  read data; 0 when not granted
o_mN_rd_valid  out  1  read data valid, routed only to the granted requester
i_mN_rd_ready  in  1  requester N read request
i_mN_lock  in  1  keep grant after the current transaction completes
o_addr  out  32  memory address
o_data  out  DATA_WIDTH  memory write data
o_wr_valid  out  1  memory write valid
i_wr_ready  in  1  memory write ready
i_data  in  DATA_WIDTH  memory read data
i_rd_valid  in  1  memory read valid
o_rd_ready  out  1  memory read ready
o_grant  out  2  one-hot current grant; 00 when idle
o_busy  out  1  state == BUSY
o_timeout  out  1  one-cycle abort pulse (0 unless ARB_TIMEOUT_EN)

Behaviour:
- Reset (async, i_rst=1): state IDLE, o_grant=00, last-served pointer=1, burst count=0, watchdog=0.
  - All memory-side outputs 0.
  - All requester-side outputs 0.
  - o_busy=0, o_timeout=0.
- Request: reqN = i_mN_wr_valid | i_mN_rd_ready.
- States IDLE and BUSY.
- IDLE:
  - Memory outputs are 0.
  - If only one requester is requesting, it wins.
  - If both are requesting, the requester that was not last served wins.
  - Winner is registered into o_grant; next state BUSY. Arbitration latency is 1 cycle.
- BUSY: combinational mux of the granted requester onto the memory port.
  - o_addr, o_data, o_wr_valid and o_rd_ready are taken from the granted requester.
  - o_mN_wr_ready, o_mN_rd_valid and o_mN_data are returned to the granted requester.
  - The non-granted requester sees 0 on all its outputs.
- Write precedence: if the granted requester asserts both wr_valid and rd_ready, o_rd_ready is forced 0 until the write completes.
- Completion: (o_wr_valid & i_wr_ready) | (i_rd_valid & o_rd_ready).
- On completion:
  - last-served <= granted requester.
  - If i_mN_lock=1 and (other requester idle or burst count+1 < MAX_BURST): stay BUSY with the same grant; burst count += 1.
  - Otherwise: next state IDLE, o_grant=00, burst count=0.
- Burst count saturates at MAX_BURST-1. It resets to 0 whenever the grant is released.
- Requesters must hold addr/data/request stable until completion. A request dropped while granted without completion leaves the grant held until a completion occurs (or timeout).
- A new request from the same requester after an unlocked completion re-arbitrates through IDLE. Consecutive unlocked transactions therefore cost 1 idle cycle each.
- Memory-side valid/ready are never registered; there is no additional data latency through the arbiter.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - A watchdog counts cycles in BUSY without a completion; it clears on completion and on leaving BUSY.
  - When the watchdog reaches TIMEOUT_CYCLES: o_timeout pulses high for 1 cycle, state goes to IDLE, o_grant=00, burst count=0, and the grant passes to the other requester if it is requesting.
  - Completion in the same cycle as the limit wins: there is no timeout.
- Undefined: no watchdog logic; o_timeout is tied 0; a grant is held indefinitely.

Test Plan:
1. Reset with only m0 reading addr 0x10:
   - o_grant=01 one cycle after request.
   - Memory returns i_data=0xAB with i_rd_valid → o_m0_data=0xAB, o_m0_rd_valid=1 the same cycle.
   - o_grant=00 next cycle.
2. Both requesters request writes in the same cycle right after reset:
   - m0 granted first (pointer=1); after completion, IDLE, then m1 granted.
   - Then both request again → m0 granted.
3. m1 holds i_m1_lock=1 and issues 6 back-to-back writes while m0 requests, MAX_BURST=4:
   - m1 completes 4 writes, then the grant is released.
   - m0 granted after 1 IDLE cycle.
4. m0 asserts wr_valid and rd_ready together:
   - o_rd_ready=0 until i_wr_ready completes the write.
   - o_m1_* remain 0 throughout.
5. i_rst asserted asynchronously mid-transaction in BUSY:
   - All outputs go to 0 immediately, without a clock edge.
   - After release, arbitration restarts with m0 winning the tie.
6. (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) m0 granted, memory never responds, m1 requesting:
   - o_timeout pulses in BUSY cycle 8.
   - m1 granted 1 cycle after the IDLE cycle.
